// File: rtl/keypad_matrix_emulator.sv
// 4x4 key-matrix emulator: presses one requested key with bounce, hold and release phases,
// answering the keyscan coder's column scan on the row lines with no clock delay.
module keypad_matrix_emulator #(
    parameter int BOUNCE_CYCLES = 16,
    parameter int BOUNCE_PERIOD = 4,
    parameter int HOLD_CYCLES   = 2000,
    parameter int GAP_CYCLES    = 500
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req,
    input  logic [3:0] KeyCode,
    output logic       Ready,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       Busy,
    output logic       Done
);

    localparam int MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAXC   = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW     = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    localparam logic [CW-1:0] B_LOAD = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(BOUNCE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        REL_BOUNCE,
        GAP
    } state_t;

    // The phase whose last cycle carries Done depends on which phases exist at all.
    localparam state_t FINAL_ST = (GAP_CYCLES > 0)    ? GAP :
                                  (BOUNCE_CYCLES > 0) ? REL_BOUNCE : HOLD;

    state_t          state, nxt_state;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic [PW-1:0]   phase, nxt_phase;
    logic            contact, nxt_contact;
    logic [3:0]      key, nxt_key;
    logic            phase_wrap;

    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_phase   = phase;
        nxt_contact = contact;
        nxt_key     = key;
        phase_wrap  = (phase == P_LAST);
        case (state)
            IDLE: begin
                if (Req) begin
                    nxt_key     = KeyCode;
                    nxt_contact = 1'b1;
                    nxt_phase   = '0;
                    if (BOUNCE_CYCLES > 0) begin
                        nxt_state = PRESS_BOUNCE;
                        nxt_cnt   = B_LOAD;
                    end else begin
                        nxt_state = HOLD;
                        nxt_cnt   = H_LOAD;
                    end
                end
            end
            PRESS_BOUNCE: begin
                if (cnt == '0) begin
                    nxt_state   = HOLD;
                    nxt_cnt     = H_LOAD;
                    nxt_contact = 1'b1;
                end else begin
                    nxt_cnt     = cnt - CW'(1);
                    nxt_phase   = phase_wrap ? '0 : phase + PW'(1);
                    // Last bounce cycle is pinned closed so HOLD starts without a glitch.
                    nxt_contact = (cnt == CW'(1)) ? 1'b1 : (contact ^ phase_wrap);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    nxt_contact = 1'b0;
                    nxt_phase   = '0;
                    if (BOUNCE_CYCLES > 0) begin
                        nxt_state = REL_BOUNCE;
                        nxt_cnt   = B_LOAD;
                    end else if (GAP_CYCLES > 0) begin
                        nxt_state = GAP;
                        nxt_cnt   = G_LOAD;
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            REL_BOUNCE: begin
                if (cnt == '0) begin
                    nxt_contact = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        nxt_state = GAP;
                        nxt_cnt   = G_LOAD;
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end
                end else begin
                    nxt_cnt     = cnt - CW'(1);
                    nxt_phase   = phase_wrap ? '0 : phase + PW'(1);
                    nxt_contact = (cnt == CW'(1)) ? 1'b0 : (contact ^ phase_wrap);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            default: begin
                nxt_state   = IDLE;
                nxt_cnt     = '0;
                nxt_contact = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= '0;
            contact <= 1'b0;
            key     <= 4'd0;
            Ready   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            phase   <= nxt_phase;
            contact <= nxt_contact;
            key     <= nxt_key;
            Ready   <= (nxt_state == IDLE);
            Busy    <= (nxt_state != IDLE);
            Done    <= (nxt_state == FINAL_ST) && (nxt_cnt == '0);
        end
    end

    always_comb begin
        Row = 4'd0;
        for (int r = 0; r < 4; r++) begin
            Row[r] = contact && (key[3:2] == 2'(r)) && Col[key[1:0]];
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: one instance without bounce, one with short bounce.
module tb_keypad_matrix_emulator;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ReqA = 1'b0, ReqB = 1'b0;
    logic [3:0] KeyA = 4'd0, KeyB = 4'd0;
    logic [3:0] ColA = 4'd0, ColB = 4'd0;
    logic [3:0] RowA, RowB;
    logic       ReadyA, ReadyB, BusyA, BusyB, DoneA, DoneB;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .HOLD_CYCLES(8), .GAP_CYCLES(3)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .Req(ReqA), .KeyCode(KeyA), .Ready(ReadyA),
        .Col(ColA), .Row(RowA), .Busy(BusyA), .Done(DoneA)
    );

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(8), .BOUNCE_PERIOD(2), .HOLD_CYCLES(4), .GAP_CYCLES(2)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .Req(ReqB), .KeyCode(KeyB), .Ready(ReadyB),
        .Col(ColB), .Row(RowB), .Busy(BusyB), .Done(DoneB)
    );

    // Leaves the bench 1 time unit into the first cycle after the accept edge.
    task automatic press_a(input logic [3:0] code);
        @(posedge Clk); #1;
        ReqA = 1'b1; KeyA = code;
        @(posedge Clk); #1;
        ReqA = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        for (int i = 0; i < 6; i++) begin
            ReqA = 1'($urandom); ReqB = 1'($urandom);
            KeyA = 4'($urandom); KeyB = 4'($urandom);
            ColA = 4'($urandom); ColB = 4'($urandom);
            @(posedge Clk); #2;
            got = {RowA != 4'd0, RowB != 4'd0, DoneA, DoneB};
            tests++;
            if (got !== 4'd0 || {ReadyA, ReadyB, BusyA, BusyB} !== 4'b1100) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: rowA=%b rowB=%b rdy=%b%b busy=%b%b done=%b%b, want rows 0 rdy 11 busy 00 done 00",
                         i, RowA, RowB, ReadyA, ReadyB, BusyA, BusyB, DoneA, DoneB);
            end
        end
        ReqA = 1'b0; ReqB = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ColA = 4'($urandom); ColB = 4'($urandom);
            @(posedge Clk); #2;
            tests++;
            if ({RowA, RowB} !== 8'd0 || {ReadyA, ReadyB, BusyA, BusyB, DoneA, DoneB} !== 6'b110000) begin
                fails++;
                $display("FAIL reset_release cyc%0d: rowA=%b rowB=%b rdy=%b%b busy=%b%b done=%b%b, want idle outputs",
                         i, RowA, RowB, ReadyA, ReadyB, BusyA, BusyB, DoneA, DoneB);
            end
        end
    endtask

    task automatic test_no_bounce();
        logic [3:0] exp_row;
        press_a(4'b0110);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) begin @(posedge Clk); #1; end
            ColA = 4'b0001 << (k % 4);
            #1;
            exp_row = (k >= 1 && k <= 8 && (k % 4) == 2) ? 4'b0010 : 4'b0000;
            tests++;
            if (RowA !== exp_row) begin
                fails++;
                $display("FAIL nobounce_row k=%0d col=%b: row=%b want %b", k, ColA, RowA, exp_row);
            end
            tests++;
            if (DoneA !== (k == 11) || ReadyA !== (k >= 12) || BusyA !== (k <= 11)) begin
                fails++;
                $display("FAIL nobounce_ctrl k=%0d: done=%b ready=%b busy=%b want %b %b %b",
                         k, DoneA, ReadyA, BusyA, k == 11, k >= 12, k <= 11);
            end
        end
        ColA = 4'd0;
    endtask

    task automatic test_bounce();
        logic [21:0] pat;
        logic [3:0]  exp_row;
        // Contact per cycle k=1..22, bit 21 is k=1.
        pat = {8'b11001101, 4'b1111, 8'b00110010, 2'b00};
        ColB = 4'b1000;
        @(posedge Clk); #1;
        ReqB = 1'b1; KeyB = 4'hF;
        @(posedge Clk); #1;
        ReqB = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) begin @(posedge Clk); #1; end
            #1;
            exp_row = (k <= 22 && pat[22 - k]) ? 4'b1000 : 4'b0000;
            tests++;
            if (RowB !== exp_row) begin
                fails++;
                $display("FAIL bounce_row k=%0d: row=%b want %b", k, RowB, exp_row);
            end
            tests++;
            if (DoneB !== (k == 22) || ReadyB !== (k >= 23)) begin
                fails++;
                $display("FAIL bounce_ctrl k=%0d: done=%b ready=%b want %b %b", k, DoneB, ReadyB, k == 22, k >= 23);
            end
        end
        ColB = 4'd0;
    endtask

    task automatic test_req_during_hold();
        int dones = 0;
        logic [3:0] exp_row;
        ColA = 4'b0110;
        press_a(4'b0110);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) begin @(posedge Clk); #1; end
            ReqA = (k >= 3 && k <= 6);
            KeyA = 4'b1001;
            #1;
            if (DoneA) dones++;
            exp_row = (k <= 8) ? 4'b0010 : 4'b0000;
            tests++;
            if (RowA !== exp_row) begin
                fails++;
                $display("FAIL ignore_req_row k=%0d: row=%b want %b", k, RowA, exp_row);
            end
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL ignore_req_done_count: got %0d want 1", dones);
        end
        ReqA = 1'b0; ColA = 4'd0;
        repeat (4) @(posedge Clk);
    endtask

    task automatic test_reset_mid_hold();
        int dones = 0;
        ColA = 4'b0100;
        press_a(4'b0110);
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (RowA !== 4'b0010) begin
            fails++;
            $display("FAIL midreset_pre: row=%b want 0010", RowA);
        end
        #1 Reset = 1'b0;
        #1;
        tests++;
        if (RowA !== 4'd0 || ReadyA !== 1'b1 || BusyA !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: row=%b ready=%b busy=%b want 0000 1 0", RowA, ReadyA, BusyA);
        end
        @(negedge Clk); Reset = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge Clk); #2;
            if (DoneA) dones++;
        end
        tests++;
        if (dones != 0 || RowA !== 4'd0) begin
            fails++;
            $display("FAIL midreset_no_done: dones=%0d row=%b want 0 0000", dones, RowA);
        end
        press_a(4'b0110);
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) begin @(posedge Clk); #1; end
            #1;
            if (k == 1) begin
                tests++;
                if (RowA !== 4'b0010) begin
                    fails++;
                    $display("FAIL midreset_reaccept_row: row=%b want 0010", RowA);
                end
            end
        end
        tests++;
        if (DoneA !== 1'b1) begin
            fails++;
            $display("FAIL midreset_reaccept_done: done=%b want 1", DoneA);
        end
        ColA = 4'd0;
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_all_keys();
        for (int code = 0; code < 16; code++) begin
            int hits = 0, bad = 0, dones = 0;
            logic [3:0] dec;
            press_a(4'(code));
            for (int k = 1; k <= 12; k++) begin
                if (k > 1) begin @(posedge Clk); #1; end
                ColA = 4'b0001 << (k % 4);
                #1;
                if (DoneA) dones++;
                if (RowA != 4'd0) begin
                    hits++;
                    case (RowA)
                        4'b0001: dec = {2'd0, 2'(k % 4)};
                        4'b0010: dec = {2'd1, 2'(k % 4)};
                        4'b0100: dec = {2'd2, 2'(k % 4)};
                        4'b1000: dec = {2'd3, 2'(k % 4)};
                        default: dec = 4'hx;
                    endcase
                    if (dec !== 4'(code)) bad++;
                end
            end
            tests++;
            if (hits != 2 || bad != 0 || dones != 1) begin
                fails++;
                $display("FAIL allkeys code=%0d: hits=%0d bad=%0d dones=%0d want 2 0 1", code, hits, bad, dones);
            end
        end
        ColA = 4'd0;
    endtask

    initial begin
        test_reset();
        test_no_bounce();
        test_bounce();
        test_req_during_hold();
        test_reset_mid_hold();
        test_all_keys();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
